// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL bring-up supervisor.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int unsigned COUNT_W = 4;

    // Timer width covering the largest cycle parameter, with one bit of headroom.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_ff2.sv
// Generic two-flop bit synchronizer with asynchronous active-high reset.
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, releases system reset,
// restarts on lock loss and latches a failure after too many lock timeouts.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 48000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 4800,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_locked,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [COUNT_W-1:0] retry_count,
    output logic [COUNT_W-1:0] loss_count
);

    localparam int unsigned TIMER_W =
        timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [COUNT_W:0]   RETRY_LIMIT  = (COUNT_W+1)'(MAX_RETRIES);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0]   retry_q, retry_d;
    logic [COUNT_W-1:0]   loss_q,  loss_d;
    logic [COUNT_W:0]     retry_inc;
    logic                 locked_s;

    sync_ff2 u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    // Extra bit so the increment never wraps when MAX_RETRIES is 15.
    assign retry_inc = {1'b0, retry_q} + (COUNT_W+1)'(1);

    // Next-state, shared timer and counter updates.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            ST_PLL_RST: begin
                if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_inc > RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_inc[COUNT_W-1:0];
                    end
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    if (loss_q != '1) loss_d = loss_q + COUNT_W'(1);
                end
            end
            ST_FAIL: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_FAIL;
                timer_d = '0;
            end
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    // State, counters and outputs; outputs decode state_d so they move with the state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_reset <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_reset <= (state_d != ST_RUN);
            ready     <= (state_d == ST_RUN);
            fail      <= (state_d == ST_FAIL);
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small parameters and a simple PLL lock model.
module tb_pll_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_drv = 1'b0;
    logic       pll_model = 1'b0;
    logic       pll_locked;
    logic       pll_reset, sys_reset, ready, fail;
    logic [3:0] retry_count, loss_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Model mode: a PLL that cannot report lock while held in reset.
    assign pll_locked = pll_model ? (lock_drv & ~pll_reset) : lock_drv;

    pll_supervisor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (3)
    ) dut (
        .clkin       (clk),
        .reset       (rst),
        .pll_locked  (pll_locked),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (!ready && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    // Reset with checks of the reset values; returns between edges just before edge 1.
    task automatic do_reset(input logic model, input logic lock);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        pll_model = model;
        lock_drv  = lock;
        step(2);
        check("rst_pll_reset", 32'(pll_reset), 1);
        check("rst_sys_reset", 32'(sys_reset), 1);
        check("rst_ready",     32'(ready), 0);
        check("rst_fail",      32'(fail), 0);
        check("rst_retry",     32'(retry_count), 0);
        check("rst_loss",      32'(loss_count), 0);
        rst = 1'b0;
    endtask

    initial begin
        int n;

        // Lock never arrives: three retries then latched failure.
        do_reset(1'b0, 1'b0);
        step(35);
        check("to1_before_retry", 32'(retry_count), 0);
        check("to1_before_prst",  32'(pll_reset), 0);
        step(1);
        check("to1_retry", 32'(retry_count), 1);
        check("to1_prst",  32'(pll_reset), 1);
        for (int r = 2; r <= 3; r++) begin
            step(36);
            check("to_retry", 32'(retry_count), 32'(r));
        end
        step(35);
        check("to4_before_fail", 32'(fail), 0);
        step(1);
        check("fail_flag",  32'(fail), 1);
        check("fail_prst",  32'(pll_reset), 1);
        check("fail_srst",  32'(sys_reset), 1);
        check("fail_ready", 32'(ready), 0);
        check("fail_retry", 32'(retry_count), 3);
        lock_drv = 1'b1;
        step(40);
        check("fail_latched",    32'(fail), 1);
        check("fail_latch_prst", 32'(pll_reset), 1);
        check("fail_latch_rdy",  32'(ready), 0);

        // Lock chatter during STABLE returns to WAIT_LOCK without a retry.
        do_reset(1'b0, 1'b0);
        step(10);
        lock_drv = 1'b1;
        step(5);
        lock_drv = 1'b0;
        step(2);
        lock_drv = 1'b1;
        step(1);
        check("chat_srst",  32'(sys_reset), 1);
        check("chat_prst",  32'(pll_reset), 0);
        check("chat_retry", 32'(retry_count), 0);
        step(9);
        check("chat_ready_early", 32'(ready), 0);
        step(1);
        check("chat_ready",       32'(ready), 1);
        check("chat_retry_final", 32'(retry_count), 0);

        // Power-up with a PLL that locks as soon as its reset drops.
        do_reset(1'b1, 1'b1);
        check("pu_prst_c0", 32'(pll_reset), 1);
        step(3);
        check("pu_prst_c3", 32'(pll_reset), 1);
        step(1);
        check("pu_prst_c4", 32'(pll_reset), 0);
        check("pu_srst_c4", 32'(sys_reset), 1);
        step(10);
        check("pu_ready_c14", 32'(ready), 0);
        step(1);
        check("pu_ready_c15", 32'(ready), 1);
        check("pu_srst_c15",  32'(sys_reset), 0);
        check("pu_retry",     32'(retry_count), 0);

        // Lock loss in RUN: sys_reset rises three cycles after the fall.
        step(5);
        lock_drv = 1'b0;
        step(2);
        check("loss_c2_ready", 32'(ready), 1);
        check("loss_c2_srst",  32'(sys_reset), 0);
        step(1);
        check("loss_c3_srst",  32'(sys_reset), 1);
        check("loss_c3_ready", 32'(ready), 0);
        check("loss_c3_prst",  32'(pll_reset), 1);
        check("loss_count1",   32'(loss_count), 1);
        lock_drv = 1'b1;
        step(3);
        check("loss_prst_c3", 32'(pll_reset), 1);
        step(1);
        check("loss_prst_c4", 32'(pll_reset), 0);
        step(10);
        check("relock_early", 32'(ready), 0);
        step(1);
        check("relock_ready", 32'(ready), 1);

        // Repeated losses saturate the loss counter.
        for (int k = 2; k <= 16; k++) begin
            lock_drv = 1'b0;
            step(3);
            check("sat_srst", 32'(sys_reset), 1);
            check("sat_loss", 32'(loss_count), (k > 15) ? 32'd15 : 32'(k));
            lock_drv = 1'b1;
            wait_ready(40, n);
            check("sat_relock_cycles", 32'(n), 15);
        end

        // Asynchronous reset between edges while in STABLE.
        lock_drv = 1'b0;
        step(3);
        lock_drv = 1'b1;
        step(10);
        check("stb_srst",  32'(sys_reset), 1);
        check("stb_prst",  32'(pll_reset), 0);
        check("stb_ready", 32'(ready), 0);
        check("stb_loss",  32'(loss_count), 15);
        #2;
        rst = 1'b1;
        #1;
        check("async_prst",  32'(pll_reset), 1);
        check("async_srst",  32'(sys_reset), 1);
        check("async_ready", 32'(ready), 0);
        check("async_fail",  32'(fail), 0);
        check("async_loss",  32'(loss_count), 0);
        check("async_retry", 32'(retry_count), 0);
        step(2);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Sequences bring-up of the board PLL (48 MHz in, 25 MHz out) and owns its reset input.
- Runs on the always-present reference clock. It pulses PLL reset, waits for a stable lock, then releases a system reset for downstream logic.
- On lock loss it re-asserts system reset and restarts the PLL. After repeated lock timeouts it enters a latched fail state.
- Sits between the pll instance and the top-level reset tree. Status bits drive the RGB LEDs.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset is held high per attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 48000: cycles allowed in WAIT_LOCK before an attempt is counted as failed (1 ms at 48 MHz).
- LOCK_STABLE_CYCLES, 4800: consecutive synchronized-locked cycles required before release (100 us).
- MAX_RETRIES, 7: failed attempts tolerated; the attempt after the last one enters FAIL. Range 1..15.

Ports:
- clkin  in  1  reference clock (48 MHz); sole clock of the block.
- reset  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clkin, synchronized internally.
- pll_reset  out  1  reset to the PLL, active-high.
- sys_reset  out  1  downstream reset, active-high, in the clkin domain. Consumers re-synchronize it into their own domain.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL; latched until reset.
- retry_count  out  4  failed attempts in the current bring-up; 0..MAX_RETRIES.
- loss_count  out  4  lock losses from RUN since reset; saturates at 15.

Behaviour:
- All outputs are registered, decoded from the next-state value, so each output changes in the same cycle as the state.
- Reset (async assert) values:
  - state=PLL_RST, pll_reset=1, sys_reset=1.
  - ready=0, fail=0.
  - retry_count=0, loss_count=0, timer=0, sync flops=0.
- Lock synchronizer: 2-flop; locked_s lags pll_locked by 2 clkin edges.
- One shared timer is cleared on every state transition and width-sized for the largest parameter.
- PLL_RST:
  - Outputs: pll_reset=1, sys_reset=1.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: pll_reset=0, sys_reset=1.
  - If locked_s=1, go to STABLE.
  - Else, if the timer reaches LOCK_TIMEOUT_CYCLES-1, increment retry_count and check it:
    - incremented value > MAX_RETRIES: go to FAIL;
    - otherwise: go to PLL_RST.
  - If locked_s rises on the same cycle as the timeout, lock wins.
- STABLE:
  - Outputs: pll_reset=0, sys_reset=1.
  - If locked_s=0, go to WAIT_LOCK. The timer restarts; retry_count is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN and clear retry_count.
- RUN:
  - Outputs: pll_reset=0, sys_reset=0, ready=1.
  - If locked_s=0, go to PLL_RST. sys_reset=1 and ready=0 in the same cycle; loss_count increments, saturating at 15.
  - A glitch shorter than one clkin period may be missed. This is accepted.
- FAIL:
  - Outputs: pll_reset=1, sys_reset=1, fail=1, ready=0.
  - Terminal; pll_locked is ignored. Only reset exits.
- Reset asserted mid-operation returns immediately to the reset values; loss_count and retry_count are cleared.
- Latency from a pll_locked rise to ready rise: 2 (sync) + 1 (WAIT_LOCK to STABLE) + LOCK_STABLE_CYCLES cycles.
- Latency from a pll_locked fall (in RUN) to sys_reset rise: 3 cycles.

Decomposition:
- Package pll_supervisor_pkg holds:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL}, 3-bit encoded;
  - constant TIMER_W = $clog2 of the largest cycle parameter, plus 1;
  - COUNT_W = 4.
- One sub-module, sync_ff2: a generic 2-flop bit synchronizer with async active-high reset, reused for pll_locked.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3):
- Power-up, pll_locked tied 1 -> pll_reset high exactly 4 cycles after reset release. ready=1 and sys_reset=0 at cycle 4+2+1+8=15 (±1 for first-edge alignment, pinned in bench). retry_count=0.
- pll_locked held 0 -> PLL_RST/WAIT_LOCK cycles 3 times, retry_count steps 1,2,3. On the 4th timeout: fail=1, pll_reset=1, sys_reset=1. Later raising pll_locked has no effect.
- Lock chatter: pll_locked high 5 cycles, low 2, high again -> state returns to WAIT_LOCK, retry_count stays 0, then ready rises 11 cycles after the final rise.
- In RUN, drop pll_locked for 3 cycles -> sys_reset=1 and ready=0 exactly 3 cycles after the fall. loss_count=1, pll_reset pulses 4 cycles, then the block returns to RUN.
- 16 lock losses in RUN -> loss_count saturates at 15.
- Assert reset asynchronously mid-STABLE, between clock edges -> all outputs at reset values before the next clkin edge; counters cleared.
